key_step_clock: RTL and testbench
=================================

KEY_STEP_CLOCK -- requirements
Module: key_step_clock

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
REQ-002 The block SHALL expose parameter PULSE_WIDTH, default 4, number of Clock cycles StepClk stays high, and also its minimum low guard time, per step.
REQ-003 The block SHALL expose parameter RUN_DIV, default 25000000, Clock cycles between automatic steps in run mode.
REQ-004 Clock  input  1  board clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  asynchronous, active-low reset.
REQ-006 KeyN  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to Clock, bouncing.
REQ-007 Run  input  1  slide switch, asynchronous; 1 = free-run mode, 0 = single-step mode.
REQ-008 StepClk  output  1  registered clock driven into the processor Clock input.
REQ-009 StepPulse  output  1  one-Clock-cycle strobe marking each accepted step.
REQ-010 StepCount  output  8  number of accepted steps, modulo 256.
REQ-011 KeyLevel  output  1  debounced key state, 1 = pressed.

Function
REQ-012 KeyN (inverted) and Run SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Debounce: counter SHALL increment each cycle the synchronized key differs from KeyLevel, clear to 0 whenever they match, and KeyLevel SHALL toggle (counter cleared) on the edge where the counter equals DEBOUNCE_CYCLES-1 with mismatch still present.
REQ-014 A key stable for DEBOUNCE_CYCLES+2 cycles after an edge on KeyN SHALL change KeyLevel; any bounce shorter than that SHALL leave KeyLevel unchanged.
REQ-015 A press event SHALL be the 0->1 transition of KeyLevel; releases SHALL generate no event.
REQ-016 Run prescaler: while synchronized Run=1 it SHALL count 0..RUN_DIV-1, emit a tick on the cycle it equals RUN_DIV-1, and wrap to 0; while Run=0 it SHALL be held at 0.
REQ-017 Step request SHALL be press event when Run=0, prescaler tick when Run=1; press events while Run=1 SHALL be ignored.
REQ-018 FSM states IDLE, HIGH, LOW: IDLE->HIGH on request; HIGH->LOW after PULSE_WIDTH cycles; LOW->IDLE after PULSE_WIDTH cycles.
REQ-019 StepClk SHALL be 1 exactly in HIGH; StepPulse SHALL be 1 only on the first cycle of HIGH.
REQ-020 StepClk and StepPulse SHALL rise on the Clock edge following the cycle in which the request is present in IDLE (1-cycle latency).
REQ-021 Requests arriving in HIGH or LOW SHALL be discarded, not queued.
REQ-022 StepCount SHALL increment by 1 with each StepPulse, wrapping 255->0.
REQ-023 Run toggling mid-step SHALL not shorten or extend the current HIGH/LOW sequence.

Reset
REQ-024 While Resetn=0: StepClk=0, StepPulse=0, StepCount=0, KeyLevel=0, FSM=IDLE, all counters 0, synchronizer flops = released/Run=0.
REQ-025 Resetn assertion mid-step SHALL abort immediately to the reset state, with StepClk forced low asynchronously.
REQ-026 After Resetn deassertion, a key already held low SHALL produce exactly one step once debounced.

Verification (DEBOUNCE_CYCLES=4, PULSE_WIDTH=2, RUN_DIV=5)
REQ-027 Run=0, KeyN falls and holds -> KeyLevel=1 six cycles later, StepPulse one cycle after that, StepClk high 2 cycles then low 2, StepCount=1.
REQ-028 KeyN low-glitches of 1, 2, 3 cycles separated by 1-cycle highs -> KeyLevel stays 0, no StepPulse, StepCount=0.
REQ-029 Run=1 held 30 cycles, key idle -> StepPulse every 5 cycles (ticks 0 and 5 both accepted since 5 >= 2*PULSE_WIDTH+1), StepCount increments per pulse; key presses during run produce no extra pulse.
REQ-030 Preload 255 steps, one more press -> StepCount=0, StepPulse asserted once.
REQ-031 Resetn pulsed low during HIGH -> StepClk=0 same cycle without waiting for an edge, all outputs 0, next press yields StepCount=1.

Source files
------------

// File: rtl/key_step_clock_if.sv
// key_step_clock_if: key/run inputs and step-clock outputs of key_step_clock
interface key_step_clock_if;
  logic       key_n;
  logic       run;
  logic       step_clk;
  logic       step_pulse;
  logic [7:0] step_count;
  logic       key_level;
  modport master (output key_n, run, input step_clk, step_pulse, step_count, key_level);
  modport slave  (input key_n, run, output step_clk, step_pulse, step_count, key_level);
endinterface

// File: rtl/key_step_clock.sv
// key_step_clock: debounced single-step / free-run clock generator for a processor
module key_step_clock #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_WIDTH     = 4,
  parameter int RUN_DIV         = 25000000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  key_step_clock_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam int RW = $clog2(RUN_DIV + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_key_sync, r_run_sync;
  logic [DW-1:0] r_db_cnt;
  logic [RW-1:0] r_run_cnt;
  logic [PW-1:0] r_ph_cnt, w_ph_cnt_nxt;
  logic          r_key_level, r_key_level_d;
  logic          r_step_clk, r_step_pulse;
  logic [7:0]    r_step_count;
  logic          w_key_mism, w_db_done, w_tick, w_press, w_req, w_accept, w_ph_done;
  assign w_key_mism = r_key_sync[1] ^ r_key_level;
  assign w_db_done  = w_key_mism && r_db_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign w_tick     = r_run_sync[1] && r_run_cnt == RW'(RUN_DIV - 1);
  assign w_press    = r_key_level && !r_key_level_d;
  assign w_req      = r_run_sync[1] ? w_tick : w_press;
  assign w_accept   = r_state == IDLE && w_req;
  assign w_ph_done  = r_ph_cnt == PW'(PULSE_WIDTH - 1);
  // two-flop synchronizers for the pressed level and the run switch
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_key_sync <= '0;
      r_run_sync <= '0;
    end else begin
      r_key_sync <= {r_key_sync[0], ~bus.key_n};
      r_run_sync <= {r_run_sync[0], bus.run};
    end
  // debounce: level flips only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_db_cnt      <= '0;
      r_key_level   <= 1'b0;
      r_key_level_d <= 1'b0;
    end else begin
      r_db_cnt      <= (w_key_mism && !w_db_done) ? r_db_cnt + DW'(1) : '0;
      r_key_level   <= r_key_level ^ w_db_done;
      r_key_level_d <= r_key_level;
    end
  // run prescaler, held at zero while run is off
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_run_cnt <= '0;
    else          r_run_cnt <= (!r_run_sync[1] || w_tick) ? '0 : r_run_cnt + RW'(1);
  // step FSM state and registered step outputs
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ph_cnt     <= '0;
      r_step_clk   <= 1'b0;
      r_step_pulse <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ph_cnt     <= w_ph_cnt_nxt;
      r_step_clk   <= w_state_nxt == HIGH;
      r_step_pulse <= w_accept;
      r_step_count <= r_step_count + 8'(w_accept);
    end
  // next state: requests are only taken in IDLE, high and low phases each last PULSE_WIDTH
  always_comb begin
    w_state_nxt  = r_state == IDLE ? (w_req ? HIGH : IDLE) :
                   r_state == HIGH ? (w_ph_done ? LOW : HIGH) :
                                     (w_ph_done ? IDLE : LOW);
    w_ph_cnt_nxt = (r_state == IDLE || w_ph_done) ? '0 : r_ph_cnt + PW'(1);
  end
  assign bus.step_clk   = r_step_clk;
  assign bus.step_pulse = r_step_pulse;
  assign bus.step_count = r_step_count;
  assign bus.key_level  = r_key_level;
endmodule

// File: tb/tb_key_step_clock.sv
// tb_key_step_clock: scoreboard bench for key_step_clock with a cycle-level reference model
module tb_key_step_clock;
  localparam int D  = 4;
  localparam int PW = 2;
  localparam int RD = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_step_clock_if bus();
  key_step_clock #(.DEBOUNCE_CYCLES(D), .PULSE_WIDTH(PW), .RUN_DIV(RD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int cnt;} exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0, pulses_seen = 0;
  int cyc, streak, run_len, busy_until, clk_until, m_count;
  bit kq[$], rq[$];
  bit lvl, lvl1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) bus.key_n = 1'b0;
    cycles(10);
    bus.key_n = 1'b1;
    cycles(10);
  endtask

  // reference model: edge-indexed view of the spec rules
  initial begin : model
    bit ks, rs, req, tick;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; streak = 0; run_len = 0; busy_until = 0; clk_until = -1; m_count = 0;
        kq = '{1'b0, 1'b0}; rq = '{1'b0, 1'b0};
        lvl = 1'b0; lvl1 = 1'b0;
        sbq.delete();
      end else begin
        cyc++;
        kq.push_back(!bus.key_n);
        rq.push_back(bus.run);
        ks = kq[0]; rs = rq[0];
        void'(kq.pop_front()); void'(rq.pop_front());
        tick = rs && (run_len % RD == RD - 1);
        run_len = rs ? run_len + 1 : 0;
        req = rs ? tick : (lvl && !lvl1);
        lvl1 = lvl;
        if (ks != lvl) begin
          streak++;
          if (streak == D) begin lvl = !lvl; streak = 0; end
        end else streak = 0;
        if (req && cyc >= busy_until) begin
          busy_until = cyc + 2 * PW + 1;
          clk_until = cyc + PW - 1;
          m_count = (m_count + 1) % 256;
          sbq.push_back('{cyc, m_count});
        end
      end
    end
  end

  // monitor: pops expected pulses and checks the live outputs every cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          checks++; failures++;
          $display("FAIL missed_pulse at_cycle=%0d expected_cycle=%0d", cyc, sbq[0].cyc);
          void'(sbq.pop_front());
        end
        if (bus.step_pulse) begin
          pulses_seen++;
          if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
            checks++; failures++;
            $display("FAIL unexpected_pulse actual_cycle=%0d expected_cycle=%0d", cyc,
                     sbq.size() > 0 ? sbq[0].cyc : -1);
          end else begin
            e = sbq.pop_front();
            check("pulse_count", int'(bus.step_count), e.cnt);
          end
        end
        check("step_clk", int'(bus.step_clk), int'(cyc > clk_until - PW && cyc <= clk_until));
        check("step_count", int'(bus.step_count), m_count);
        check("key_level", int'(bus.key_level), int'(lvl));
      end
    end
  end

  initial begin : stim
    int p0, tries;
    bit seen;
    bus.key_n = 1'b1; bus.run = 1'b0; rst_n = 1'b0;
    cycles(3);
    check("rst_step_clk", int'(bus.step_clk), 0);
    check("rst_step_pulse", int'(bus.step_pulse), 0);
    check("rst_step_count", int'(bus.step_count), 0);
    check("rst_key_level", int'(bus.key_level), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    cycles(2);
    // single press: level after 6 edges, pulse on the 7th, clk high 2 then low
    @(negedge clk) bus.key_n = 1'b0;
    cycles(5); check("press_level_early", int'(bus.key_level), 0);
    cycles(1); check("press_level", int'(bus.key_level), 1);
    check("press_no_pulse_yet", int'(bus.step_pulse), 0);
    cycles(1); check("press_pulse", int'(bus.step_pulse), 1);
    check("press_clk_hi1", int'(bus.step_clk), 1);
    check("press_count", int'(bus.step_count), 1);
    cycles(1); check("press_clk_hi2", int'(bus.step_clk), 1);
    check("press_pulse_once", int'(bus.step_pulse), 0);
    cycles(1); check("press_clk_lo", int'(bus.step_clk), 0);
    cycles(10); bus.key_n = 1'b1; cycles(12);
    // glitches of 1, 2, 3 cycles separated by single highs
    @(negedge clk) bus.key_n = 1'b0; cycles(1);
    bus.key_n = 1'b1; cycles(1);
    bus.key_n = 1'b0; cycles(2);
    bus.key_n = 1'b1; cycles(1);
    bus.key_n = 1'b0; cycles(3);
    bus.key_n = 1'b1; cycles(12);
    check("glitch_count", int'(bus.step_count), 1);
    check("glitch_level", int'(bus.key_level), 0);
    // free run for 30 cycles with a key press in the middle
    p0 = pulses_seen;
    @(negedge clk) bus.run = 1'b1;
    cycles(10); bus.key_n = 1'b0;
    cycles(8);  bus.key_n = 1'b1;
    cycles(12); bus.run = 1'b0;
    cycles(14);
    check("run_pulses", pulses_seen - p0, 6);
    check("run_count", int'(bus.step_count), 7);
    // randomized key/run activity
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.key_n = 1'($urandom_range(0, 1));
      bus.run = ($urandom_range(0, 4) == 0);
      cycles($urandom_range(1, 9));
    end
    bus.key_n = 1'b1; bus.run = 1'b0;
    cycles(20);
    // preload toward 255 with run, finish with presses, then wrap
    @(negedge clk) bus.run = 1'b1;
    tries = 0;
    while (m_count != 250 && tries < 3000) begin @(negedge clk); tries++; end
    bus.run = 1'b0;
    cycles(10);
    tries = 0;
    while (m_count != 255 && tries < 10) begin press(); tries++; end
    check("preload_255", int'(bus.step_count), 255);
    p0 = pulses_seen;
    press();
    check("wrap_count", int'(bus.step_count), 0);
    check("wrap_pulses", pulses_seen - p0, 1);
    // reset during HIGH, key kept held through and after reset
    @(negedge clk) bus.key_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.step_clk;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_step_clk actual=timeout required=high within 20 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk", int'(bus.step_clk), 0);
    check("async_rst_pulse", int'(bus.step_pulse), 0);
    check("async_rst_count", int'(bus.step_count), 0);
    check("async_rst_level", int'(bus.key_level), 0);
    cycles(2);
    @(negedge clk); #2 rst_n = 1'b1;
    cycles(20);
    check("held_key_one_step", int'(bus.step_count), 1);
    cycles(20);
    check("held_key_still_one", int'(bus.step_count), 1);
    bus.key_n = 1'b1;
    cycles(12);
    press();
    check("after_rst_press", int'(bus.step_count), 2);
    cycles(5);
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
